// File: rtl/mod12_pkg.sv
// Shared constants and count type for the modulo-12 down counter.
package mod12_pkg;

  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MOD12_MAX = 4'd11;
  localparam cnt_t MOD12_MIN = 4'd0;

endpackage

// File: rtl/mod12_clamp.sv
// Load-value limiter: passes d through, saturating anything above MOD12_MAX.
module mod12_clamp
  import mod12_pkg::*;
(
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] clamped_c
);

  assign clamped_c = (d > MOD12_MAX) ? MOD12_MAX : d;

endmodule

// File: rtl/mod12_down.sv
// Modulo-12 down counter with synchronous load, wrap borrow pulse and
// optional one-shot mode (ports oneshot/busy) under MOD12_DOWN_ONESHOT_EN.
module mod12_down
  import mod12_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] d,
`ifdef MOD12_DOWN_ONESHOT_EN
  input  logic             oneshot,
  output logic             busy,
`endif
  output logic [CNT_W-1:0] Q,
  output logic             zero,
  output logic             borrow
);

  cnt_t d_clamped;
  cnt_t q_next;
  logic borrow_next;

  mod12_clamp u_clamp (
    .d         (d),
    .clamped_c (d_clamped)
  );

`ifdef MOD12_DOWN_ONESHOT_EN
  logic busy_next;

  // Count register: clr > load > en > hold; one-shot mode parks at zero.
  always_comb begin
    q_next      = Q;
    borrow_next = 1'b0;
    busy_next   = busy;
    if (load) begin
      q_next    = d_clamped;
      busy_next = (d_clamped != MOD12_MIN);
    end else if (en) begin
      if (Q == MOD12_MIN) begin
        if (!oneshot) begin
          q_next      = MOD12_MAX;
          borrow_next = 1'b1;
        end
      end else begin
        q_next = Q - cnt_t'(1);
        if (q_next == MOD12_MIN) begin
          busy_next = 1'b0;
        end
      end
    end
    if (!oneshot) begin
      busy_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q      <= MOD12_MIN;
      borrow <= 1'b0;
      busy   <= 1'b0;
    end else begin
      Q      <= q_next;
      borrow <= borrow_next;
      busy   <= busy_next;
    end
  end
`else
  // Count register: clr > load > en > hold; always wraps 0 -> 11.
  always_comb begin
    q_next      = Q;
    borrow_next = 1'b0;
    if (load) begin
      q_next = d_clamped;
    end else if (en) begin
      if (Q == MOD12_MIN) begin
        q_next      = MOD12_MAX;
        borrow_next = 1'b1;
      end else begin
        q_next = Q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q      <= MOD12_MIN;
      borrow <= 1'b0;
    end else begin
      Q      <= q_next;
      borrow <= borrow_next;
    end
  end
`endif

  assign zero = (Q == MOD12_MIN);

endmodule

// File: tb/tb_mod12_down.sv
// Self-checking bench for mod12_down; directed scenarios plus randomized
// stimulus against an arithmetic reference model.
module tb_mod12_down;

  logic       clk;
  logic       clr;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [3:0] Q;
  logic       zero;
  logic       borrow;
`ifdef MOD12_DOWN_ONESHOT_EN
  logic       oneshot;
  logic       busy;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q;
  bit m_borrow;
  bit m_busy;

  mod12_down dut (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .load   (load),
    .d      (d),
`ifdef MOD12_DOWN_ONESHOT_EN
    .oneshot(oneshot),
    .busy   (busy),
`endif
    .Q      (Q),
    .zero   (zero),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one edge, advance the model, sample 1ns after the edge.
  task automatic tick(input bit e, input bit l, input int dv, input bit os);
    int nq;
    bit nb;
    bit nbusy;
    en   = e;
    load = l;
    d    = 4'(dv);
`ifdef MOD12_DOWN_ONESHOT_EN
    oneshot = os;
`endif
    nq    = m_q;
    nb    = 0;
    nbusy = m_busy;
    if (l) begin
      nq    = (dv > 11) ? 11 : dv;
      nbusy = (nq != 0);
    end else if (e) begin
      if (os && m_q == 0) begin
        nq = 0;
      end else begin
        nq = (m_q + 11) % 12;
        nb = (m_q == 0);
        if (nq == 0) nbusy = 0;
      end
    end
    if (!os) nbusy = 0;
    @(posedge clk);
    #1;
    m_q      = nq;
    m_borrow = nb;
    m_busy   = nbusy;
  endtask

  task automatic model_reset();
    m_q      = 0;
    m_borrow = 0;
    m_busy   = 0;
  endtask

  task automatic test_reset();
    clr  = 1'b1;
    en   = 1'b1;
    load = 1'b0;
    d    = 4'd9;
`ifdef MOD12_DOWN_ONESHOT_EN
    oneshot = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", Q); end
    checks++;
    if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++;
    if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow); end
`ifdef MOD12_DOWN_ONESHOT_EN
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`endif
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_load_count();
    int exp_q[7] = '{4, 3, 2, 1, 0, 11, 10};
    tick(0, 1, 5, 0);
    checks++;
    if (Q !== 4'd5) begin errors++; $display("FAIL load5_q: got %0d want 5", Q); end
    for (int i = 0; i < 7; i++) begin
      tick(1, 0, 0, 0);
      checks++;
      if (Q !== 4'(exp_q[i])) begin
        errors++; $display("FAIL count_q[%0d]: got %0d want %0d", i, Q, exp_q[i]);
      end
      checks++;
      if (borrow !== (exp_q[i] == 11)) begin
        errors++; $display("FAIL count_borrow[%0d]: got %b want %b", i, borrow, exp_q[i] == 11);
      end
      checks++;
      if (zero !== (exp_q[i] == 0)) begin
        errors++; $display("FAIL count_zero[%0d]: got %b want %b", i, zero, exp_q[i] == 0);
      end
    end
  endtask

  task automatic test_clamp();
    int dv[4]  = '{15, 12, 11, 0};
    int exp[4] = '{11, 11, 11, 0};
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, 1, dv[i], 0);
      checks++;
      if (Q !== 4'(exp[i])) begin
        errors++; $display("FAIL clamp_q[d=%0d]: got %0d want %0d", dv[i], Q, exp[i]);
      end
      checks++;
      if (borrow !== 1'b0) begin
        errors++; $display("FAIL clamp_borrow[d=%0d]: got %b want 0", dv[i], borrow);
      end
    end
  endtask

  task automatic test_load_priority();
    // Q is 0 here: en alone would wrap, load must win.
    tick(1, 1, 3, 0);
    checks++;
    if (Q !== 4'd3) begin errors++; $display("FAIL prio_q: got %0d want 3", Q); end
    checks++;
    if (borrow !== 1'b0) begin errors++; $display("FAIL prio_borrow: got %b want 0", borrow); end
  endtask

  task automatic test_hold();
    int exp_q[3] = '{1, 1, 0};
    bit ens[3]   = '{1'b1, 1'b0, 1'b1};
    tick(0, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick(ens[i], 0, 0, 0);
      checks++;
      if (Q !== 4'(exp_q[i])) begin
        errors++; $display("FAIL hold_q[%0d]: got %0d want %0d", i, Q, exp_q[i]);
      end
      checks++;
      if (borrow !== 1'b0) begin
        errors++; $display("FAIL hold_borrow[%0d]: got %b want 0", i, borrow);
      end
    end
  endtask

  task automatic test_async_clr();
    tick(0, 1, 9, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    checks++;
    if (Q !== 4'd7) begin errors++; $display("FAIL preclr_q: got %0d want 7", Q); end
    en = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    checks++;
    if (Q !== 4'd0) begin errors++; $display("FAIL asyncclr_q: got %0d want 0", Q); end
    checks++;
    if (borrow !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL asyncclr_flags: got borrow=%b zero=%b want 0/1", borrow, zero);
    end
    #1;
    clr = 1'b0;
    // First edge after release applies normal priority: wrap from 0.
    tick(1, 0, 0, 0);
    checks++;
    if (Q !== 4'd11 || borrow !== 1'b1) begin
      errors++; $display("FAIL postclr: got Q=%0d borrow=%b want 11/1", Q, borrow);
    end
  endtask

`ifdef MOD12_DOWN_ONESHOT_EN
  task automatic test_oneshot();
    int  exp_q[5]    = '{2, 1, 0, 0, 0};
    bit  exp_busy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tick(0, 1, 2, 1);
    checks++;
    if (Q !== 4'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL os_load: got Q=%0d busy=%b want 2/1", Q, busy);
    end
    for (int i = 1; i < 5; i++) begin
      tick(1, 0, 0, 1);
      checks++;
      if (Q !== 4'(exp_q[i]) || busy !== exp_busy[i] || borrow !== 1'b0) begin
        errors++;
        $display("FAIL os_step[%0d]: got Q=%0d busy=%b borrow=%b want %0d/%b/0",
                 i, Q, busy, borrow, exp_q[i], exp_busy[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit os = 0;
    for (int i = 0; i < 400; i++) begin
`ifdef MOD12_DOWN_ONESHOT_EN
      if (i % 40 == 0) os = 1'($urandom_range(0, 1));
`endif
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 15)), os);
      checks++;
      if (Q !== 4'(m_q) || zero !== (m_q == 0) || borrow !== m_borrow) begin
        errors++;
        $display("FAIL rand[%0d]: got Q=%0d zero=%b borrow=%b want %0d/%b/%b",
                 i, Q, zero, borrow, m_q, m_q == 0, m_borrow);
      end
`ifdef MOD12_DOWN_ONESHOT_EN
      checks++;
      if (busy !== m_busy) begin
        errors++; $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, m_busy);
      end
`endif
      if ($urandom_range(0, 49) == 0) begin
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (Q !== 4'd0 || borrow !== 1'b0) begin
          errors++; $display("FAIL rand_clr[%0d]: got Q=%0d borrow=%b want 0/0", i, Q, borrow);
        end
        clr = 1'b0;
      end
    end
  endtask

  initial begin
    clr  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    d    = 4'd0;
    #2;
    test_reset();
    test_load_count();
    test_clamp();
    test_load_priority();
    test_hold();
    test_async_clr();
`ifdef MOD12_DOWN_ONESHOT_EN
    test_oneshot();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod12_down.md
MOD12_DOWN -- requirements
Module: mod12_down

Interface
REQ-001 The block SHALL have no parameters; modulus is fixed at 12 (count range 11..0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  count enable; when high, decrement once per clock.
REQ-005 load  input  1  synchronous parallel load strobe.
REQ-006 d  input  4  parallel load value.
REQ-007 Q  output  4  registered count value, range 0..11.
REQ-008 zero  output  1  combinational; high when Q == 0.
REQ-009 borrow  output  1  registered; one-cycle pulse on each 0 -> 11 wrap.
REQ-010 busy  output  1  registered; present only when MOD12_DOWN_ONESHOT_EN is defined (see REQ-024).
REQ-011 oneshot  input  1  mode select; present only when MOD12_DOWN_ONESHOT_EN is defined.

Function
REQ-012 Priority per clock edge SHALL be clr > load > en > hold.
REQ-013 With load=1, Q SHALL take d next cycle; d > 11 SHALL clamp to 11; borrow SHALL be 0 that cycle.
REQ-014 With load=0, en=1, Q != 0, Q SHALL become Q-1 next cycle; borrow SHALL be 0.
REQ-015 With load=0, en=1, Q == 0 (wrap mode), Q SHALL become 11 and borrow SHALL be 1 for exactly the following cycle.
REQ-016 With load=0, en=0, Q and busy SHALL hold; borrow SHALL be 0.
REQ-017 Continuous en SHALL produce sequence 11,10,...,1,0,11,... with borrow high once per 12 enabled cycles.
REQ-018 Q SHALL never hold a value above 11 in any cycle after reset.
REQ-019 zero SHALL track Q with no register delay.
REQ-020 load and en asserted together SHALL behave as load only; no decrement, no borrow.

Reset
REQ-021 clr=1 SHALL force Q=0, borrow=0, busy=0 immediately, regardless of clk.
REQ-022 clr asserted mid-count SHALL abort the count; after release, the first rising edge SHALL apply REQ-012 normally.
REQ-023 Outputs after reset: Q=0, zero=1, borrow=0, busy=0.

Configuration
REQ-024 Macro MOD12_DOWN_ONESHOT_EN defined: ports oneshot and busy exist.
- oneshot=1: Q stops at 0 (no wrap, no borrow); en at Q==0 is ignored.
- busy sets on a load with clamped d != 0 and clears on the edge where Q reaches 0.
- oneshot=0: behaviour identical to macro-undefined build; busy held 0.
REQ-025 Macro undefined: ports oneshot and busy SHALL be absent; counter always wraps per REQ-015.

Structure
REQ-026 Shared package mod12_pkg SHALL hold MOD12_MAX (4'd11), MOD12_MIN (4'd0), and the 4-bit count typedef.
REQ-027 Sub-module mod12_clamp (combinational, d -> min(d, 11)) SHALL be used for the load path; all other logic lives in mod12_down.

Verification
REQ-028 Assert clr mid-count at Q=7 between clock edges -> Q=0, borrow=0 without waiting for clk.
REQ-029 Load d=5, then en high 7 cycles -> Q 5,4,3,2,1,0,11; borrow high only in the cycle after the 0->11 edge; zero high only while Q=0.
REQ-030 Load d=15 -> Q=11; load d=0 with en=1 -> Q=0, no borrow.
REQ-031 Q=0, load=1, d=3, en=1 on the same edge -> Q=3, borrow=0.
REQ-032 en toggled 1,0,1 from Q=2 -> Q 1,1,0; hold cycle shows no borrow.
REQ-033 ONESHOT_EN build, oneshot=1: load d=2, en high 5 cycles -> Q 2,1,0,0,0; busy 1 until Q=0 then 0; borrow never asserted.
